// File: rtl/prio_dec_pkg.sv
// Shared types for the sequential 4:2 priority decoder.
//   DEF_IDX_W   : default encoded-index width (output is 2**DEF_IDX_W bits)
//   DEF_CNT_W   : default width of each saturating hit counter
//   dec_entry_t : queued word, {none, idx}; none=1 means the encoder saw
//                 no active input and idx carries no information
//   q_state_t   : occupancy of the 2-entry queue
package prio_dec_pkg;

    localparam int DEF_IDX_W = 2;
    localparam int DEF_CNT_W = 8;

    typedef struct packed {
        logic                 none;
        logic [DEF_IDX_W-1:0] idx;
    } dec_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

endpackage

// File: rtl/prio_dec_fifo2.sv
// Two-entry FIFO with valid/ready on both sides, controlled by an
// EMPTY/ONE/FULL state machine. in_ready and out_valid are registers that
// depend only on occupancy, so there is no combinational path from
// out_ready to in_ready nor from the input to the output.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : push handshake, in_data is the pushed entry
//   out_valid/out_ready  : pop handshake, out_data is the queue head
module prio_dec_fifo2
    import prio_dec_pkg::*;
#(
    parameter type T = dec_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    q_state_t r_state;
    T         r_head;
    T         r_tail;
    logic     r_in_ready;
    logic     r_out_valid;

    logic w_push;
    logic w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Entry registers load only on a push, so undriven/X payload presented
    // while in_valid=0 never reaches state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= Q_EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                Q_EMPTY: begin
                    if (w_push) begin
                        r_head      <= in_data;
                        r_state     <= Q_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                Q_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_tail     <= in_data;
                            r_state    <= Q_FULL;
                            r_in_ready <= 1'b0;
                        end
                        2'b01: begin
                            r_state     <= Q_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                        // Simultaneous push and pop: the new word replaces
                        // the departing head, occupancy stays at one.
                        2'b11: r_head <= in_data;
                        default: ;
                    endcase
                end
                Q_FULL: begin
                    if (w_pop) begin
                        r_head     <= r_tail;
                        r_state    <= Q_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= Q_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;

endmodule

// File: rtl/prio_decoder.sv
// Sequential inverse of a 2**IDX_W:IDX_W priority encoder. Encoded words
// {in_none, in_idx} are queued in a 2-entry FIFO; the head is decoded to a
// one-hot word. Every delivered word bumps a saturating counter: one per
// output line, plus one for "none" words.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_idx, in_none are the payload
//   out_valid/out_ready  : output handshake; out_onehot is the decoded word
//   clr_cnt              : synchronous clear of all counters (wins over +1)
//   hit_cnt              : flattened per-line counters, line k at [k*CNT_W +: CNT_W]
//   none_cnt             : number of delivered "none" words
module prio_decoder
    import prio_dec_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IDX_W-1:0]            in_idx,
    input  logic                        in_none,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2**IDX_W-1:0]         out_onehot,
    input  logic                        clr_cnt,
    output logic [(2**IDX_W)*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]            none_cnt
);

    localparam int N_LINES = 2**IDX_W;

    // Same layout as dec_entry_t, sized by this instance's IDX_W.
    typedef struct packed {
        logic             none;
        logic [IDX_W-1:0] idx;
    } entry_t;

    entry_t w_in_entry;
    entry_t w_head;
    logic   w_out_valid;
    logic   w_pop;

    assign w_in_entry = '{none: in_none, idx: in_idx};

    prio_dec_fifo2 #(
        .T(entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_entry),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_head)
    );

    assign out_valid = w_out_valid;
    assign w_pop     = w_out_valid & out_ready;

    // Decode is gated by out_valid so a stale head in an empty queue
    // shows as all zeros.
    logic [N_LINES-1:0] w_onehot;

    generate
        for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
            logic [CNT_W-1:0] r_cnt;

            assign w_onehot[gi] = w_out_valid & ~w_head.none & (w_head.idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clr_cnt) begin
                    r_cnt <= '0;
                end else if (w_pop && w_onehot[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign hit_cnt[gi*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

    assign out_onehot = w_onehot;

    logic [CNT_W-1:0] r_none_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_none_cnt <= '0;
        end else if (clr_cnt) begin
            r_none_cnt <= '0;
        end else if (w_pop && w_head.none && (r_none_cnt != '1)) begin
            r_none_cnt <= r_none_cnt + 1'b1;
        end
    end

    assign none_cnt = r_none_cnt;

endmodule

// File: doc/prio_decoder.md
Name: prio_decoder

Overview:
- Sequential inverse of the 4:2 priority encoder.
- Accepts an encoded index (y1,y0 style) plus a "no input active" flag over a valid/ready handshake, buffers it in a 2-entry queue, and presents the decoded one-hot word on a valid/ready output.
- Keeps saturating per-line hit counters so the encoder/decoder pair can be checked end to end in loopback.

Parameters:
- IDX_W, 2: width of the encoded index; output width is 2**IDX_W.
- CNT_W, 8: width of each saturating hit counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  encoded word present.
- in_ready  output  1  decoder can accept the word this cycle.
- in_idx  input  IDX_W  encoded index (y1 = MSB).
- in_none  input  1  encoder saw no active input; in_idx is ignored.
- out_valid  output  1  decoded word present.
- out_ready  input  1  consumer accepts the word this cycle.
- out_onehot  output  2**IDX_W  decoded word: bit in_idx set, or all zeros for none.
- clr_cnt  input  1  synchronous clear of all counters.
- hit_cnt  output  (2**IDX_W)*CNT_W  flattened counters; line k occupies bits [k*CNT_W +: CNT_W].
- none_cnt  output  CNT_W  count of "none" words delivered.

Behaviour:
- Reset (async, rst=1):
  - queue empties; in_ready=1, out_valid=0, out_onehot=0.
  - all hit_cnt=0, none_cnt=0.
  - Takes effect immediately, including mid-transfer; queued words are discarded.
- Input push: occurs on an edge where in_valid & in_ready. The entry stored is {in_none, in_idx}.
- Output pop: occurs on an edge where out_valid & out_ready.
- Decode is combinational from the queue head:
  - out_onehot = in_none ? 0 : (1 << idx).
  - Output is held stable while out_valid=1 and out_ready=0.
- Queue FSM, states EMPTY, ONE, FULL:
  - EMPTY: out_valid=0, in_ready=1. Push -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - push only -> FULL
    - pop only -> EMPTY
    - push & pop -> ONE; the new word becomes head next cycle.
  - FULL: out_valid=1, in_ready=0. Pop -> ONE; tail becomes head.
- Latency: a word pushed at edge t has out_valid=1 from edge t onward (visible in the cycle after t) when the queue was EMPTY. There is no combinational in->out path.
- in_ready depends only on state, never on out_ready, so there is no combinational ready path.
- Ordering is strict FIFO; no word is dropped or duplicated.
- Counters:
  - Update on pop only: hit_cnt[idx]++ when none=0, none_cnt++ when none=1.
  - Saturate at 2**CNT_W-1 and never wrap.
  - clr_cnt=1 zeroes all counters at the edge and takes priority over a same-cycle increment.
- in_idx/in_none are don't-care when in_valid=0; X on them must not propagate into state.

Decomposition:
- Package prio_dec_pkg holds:
  - IDX_W default;
  - typedef dec_entry_t = struct {none; idx};
  - enum q_state_t {Q_EMPTY, Q_ONE, Q_FULL}.
- One sub-module, prio_dec_fifo2: the 2-entry queue with its state machine, parameterized on entry type.
- The top level holds the decode and the counter logic.

Test Plan:
- Reset then single word: push idx=2, none=0 with out_ready=1 -> out_valid the next cycle, out_onehot=4'b0100, then hit_cnt[2]=1 and all other counters 0.
- Backpressure: out_ready=0, push idx=0 then idx=3 -> FULL and in_ready=0 after the second push. A third word is held off. Raising out_ready then yields 4'b0001 followed by 4'b1000, in order.
- None word: push none=1, idx=3 -> out_onehot=4'b0000, none_cnt=1, hit_cnt[3] unchanged.
- Loopback with the 4:2 encoder: drive i3..i0 through 0001, 0010, 0100, 1000 -> outputs 0001, 0010, 0100, 1000 in order, each hit_cnt=1.
- Saturation and clear:
  - 300 pops of idx=1 with CNT_W=8 -> hit_cnt[1]=255, no wrap.
  - clr_cnt asserted in the same cycle as a pop -> all counters 0.
- Async reset mid-operation: assert rst between clock edges while FULL -> out_valid=0 and in_ready=1 immediately, counters 0, no stale word after release.
